// File: rtl/stamped_sync_fifo.sv
// FWFT sync FIFO with a free-running 64-bit cycle timestamp.
// SOFT_FIFO_EN selects flop storage; default is RAM plus prefetch reg.
module stamped_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wrreq,
  input  logic [WIDTH-1:0]     data,
  input  logic                 rdreq,
  output logic [WIDTH-1:0]     q,
  output logic                 full,
  output logic                 empty,
  output logic [LOG_DEPTH:0]   counter,
  input  logic                 ts_inc,
  output logic [63:0]          timestamp,
  output logic                 overflow
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]   CNT_FULL = DEPTH[LOG_DEPTH:0];
  localparam logic [LOG_DEPTH:0]   CNT_ONE  = 1;
  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic                 wr_acc;
  logic                 rd_acc;

  assign full   = (counter == CNT_FULL);
  assign wr_acc = wrreq & ~full;
  assign rd_acc = rdreq & ~empty;

  // Storage is never reset so it can map onto a RAM macro.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      counter  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (wrreq && full) overflow <= 1'b1;
      unique case (1'b1)
        (wr_acc && !rd_acc): counter <= counter + CNT_ONE;
        (rd_acc && !wr_acc): counter <= counter - CNT_ONE;
        default:             counter <= counter;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    timestamp <= '0;
    else if (ts_inc) timestamp <= timestamp + 64'd1;
  end

`ifdef SOFT_FIFO_EN

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    rd_ptr <= '0;
    else if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
  end

  assign empty = (counter == '0);
  assign q     = empty ? '0 : mem[rd_ptr];

`else

  logic [LOG_DEPTH:0] ram_cnt;
  logic               q_valid;
  logic [WIDTH-1:0]   q_reg;
  logic               fetch;

  // Refill the prefetch reg whenever it is free or being consumed.
  assign fetch = (ram_cnt != '0) && (!q_valid || rd_acc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      ram_cnt <= '0;
      q_valid <= 1'b0;
      q_reg   <= '0;
    end else begin
      if (fetch) begin
        q_reg  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      q_valid <= fetch | (q_valid & ~rd_acc);
      unique case (1'b1)
        (wr_acc && !fetch): ram_cnt <= ram_cnt + CNT_ONE;
        (fetch && !wr_acc): ram_cnt <= ram_cnt - CNT_ONE;
        default:            ram_cnt <= ram_cnt;
      endcase
    end
  end

  assign empty = ~q_valid;
  assign q     = q_reg;

`endif

endmodule

// File: tb/tb_stamped_sync_fifo.sv
// Scoreboard bench for stamped_sync_fifo (WIDTH=8, LOG_DEPTH=2).
// Stimulus pushes expected data; a negedge monitor checks each pop.
module tb_stamped_sync_fifo;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wrreq;
  logic [7:0]  data;
  logic        rdreq;
  logic [7:0]  q;
  logic        full;
  logic        empty;
  logic [2:0]  counter;
  logic        ts_inc;
  logic [63:0] timestamp;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

`ifdef SOFT_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  stamped_sync_fifo #(.WIDTH(8), .LOG_DEPTH(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wrreq     (wrreq),
    .data      (data),
    .rdreq     (rdreq),
    .q         (q),
    .full      (full),
    .empty     (empty),
    .counter   (counter),
    .ts_inc    (ts_inc),
    .timestamp (timestamp),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    wrreq = 1'b1;
    data  = d;
    sb.push_back(d);
  endtask

  // Monitor: every accepted pop must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset_n && rdreq && !empty) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop: got %0h expected nothing", q);
      end else begin
        chk("pop_q", {56'd0, q}, {56'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fill [4];
    int lat;
    fill[0] = 8'h11; fill[1] = 8'h22;
    fill[2] = 8'h33; fill[3] = 8'h44;
    reset_n = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
    data = '0; ts_inc = 1'b0;
    repeat (3) step();
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_q", {56'd0, q}, 64'd0);
    reset_n = 1'b1;
    step();
    chk("rst_counter", {61'd0, counter}, 64'd0);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_ts", timestamp, 64'd0);

    for (int i = 0; i < 4; i++) begin
      put(fill[i]);
      step();
      chk("fill_counter", {61'd0, counter}, 64'(i + 1));
    end
    chk("fill_full", {63'd0, full}, 64'd1);
    data = 8'h55;
    step();
    wrreq = 1'b0;
    chk("drop_ovf", {63'd0, overflow}, 64'd1);
    chk("drop_counter", {61'd0, counter}, 64'd4);
    step();

    rdreq = 1'b1;
    repeat (4) step();
    rdreq = 1'b0;
    chk("drain_counter", {61'd0, counter}, 64'd0);
    chk("drain_empty", {63'd0, empty}, 64'd1);
    rdreq = 1'b1;
    step();
    rdreq = 1'b0;
    chk("under_counter", {61'd0, counter}, 64'd0);
    chk("under_full", {63'd0, full}, 64'd0);

    put(8'h01); step();
    put(8'h02); step();
    wrreq = 1'b0;
    repeat (3) step();
    chk("rw_pre_counter", {61'd0, counter}, 64'd2);
    for (int k = 0; k < 10; k++) begin
      put(8'h10 + 8'(k));
      rdreq = 1'b1;
      step();
      chk("rw_counter", {61'd0, counter}, 64'd2);
    end
    wrreq = 1'b0;
    repeat (2) step();
    rdreq = 1'b0;
    chk("rw_post_counter", {61'd0, counter}, 64'd0);
    chk("rw_post_empty", {63'd0, empty}, 64'd1);

    put(8'hA5);
    step();
    wrreq = 1'b0;
    lat = 1;
    while (empty && lat < 6) begin
      step();
      lat++;
    end
    chk("wr_latency", 64'(lat), 64'(LAT));
    chk("lat_q", {56'd0, q}, 64'hA5);
    rdreq = 1'b1;
    step();
    rdreq = 1'b0;
    chk("lat_counter", {61'd0, counter}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    ts_inc = 1'b1;
    repeat (100) step();
    ts_inc = 1'b0;
    chk("ts_100", timestamp, 64'd100);
    repeat (5) step();
    chk("ts_hold", timestamp, 64'd100);

    wrreq = 1'b1;
    data  = 8'h77;
    step();
    wrreq = 1'b0;
    repeat (2) step();
    chk("pre_rst_empty", {63'd0, empty}, 64'd0);
    chk("pre_rst_ovf", {63'd0, overflow}, 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_ts", timestamp, 64'd0);
    chk("arst_empty", {63'd0, empty}, 64'd1);
    chk("arst_ovf", {63'd0, overflow}, 64'd0);
    chk("arst_counter", {61'd0, counter}, 64'd0);
    sb.delete();
    step();
    reset_n = 1'b1;
    repeat (2) step();
    chk("post_rst_empty", {63'd0, empty}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
